// File: rtl/feed_forward_multi_layer.sv
// Fixed-point multi-layer perceptron evaluated one multiply-accumulate per fetched weight.
// Weights arrive over a single-outstanding request/response port; hidden activations ping-pong between two banks.
module feed_forward_multi_layer #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned FRAC_BITS         = 8,
    parameter int unsigned NUM_INPUT         = 2,
    parameter int unsigned NUM_HIDDEN        = 32,
    parameter int unsigned NUM_HIDDEN_LAYERS = 2,
    parameter int unsigned NUM_OUTPUT        = 3,
    parameter int unsigned LAYER_WIDTH       = 2,
    parameter int unsigned ADDR_WIDTH        = 6,
    parameter int unsigned WADDR_WIDTH       = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_data_valid,
    input  logic [ADDR_WIDTH-1:0]  i_data_addr,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_weight_valid_request,
    output logic [LAYER_WIDTH-1:0] o_weight_layer_request,
    output logic [WADDR_WIDTH-1:0] o_weight_addr_request,
    input  logic                   i_weight_valid,
    input  logic [DATA_WIDTH-1:0]  i_weight,
    output logic                   o_data_valid,
    output logic [LAYER_WIDTH-1:0] o_data_layer,
    output logic [ADDR_WIDTH-1:0]  o_data_addr,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_done
);

    localparam int unsigned ACC_W   = 2 * DATA_WIDTH + 8;
    localparam int unsigned PROD_W  = 2 * DATA_WIDTH;
    localparam int unsigned FAN_MAX = (NUM_INPUT > NUM_HIDDEN) ? NUM_INPUT : NUM_HIDDEN;
    localparam int unsigned K_W     = $clog2(FAN_MAX + 1);

    localparam logic [LAYER_WIDTH-1:0]      OUT_LAYER = LAYER_WIDTH'(NUM_HIDDEN_LAYERS);
    localparam logic signed [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1 << FRAC_BITS);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FINISH,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [LAYER_WIDTH-1:0]  layer_q, layer_d;
    logic [ADDR_WIDTH-1:0]   node_q, node_d;
    logic [K_W-1:0]          k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic                   busy_q, busy_d;
    logic                   wreq_q, wreq_d;
    logic [LAYER_WIDTH-1:0] wlayer_q, wlayer_d;
    logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                   dvalid_q, dvalid_d;
    logic [LAYER_WIDTH-1:0] dlayer_q, dlayer_d;
    logic [ADDR_WIDTH-1:0]  daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   done_q, done_d;

    logic signed [DATA_WIDTH-1:0] in_buf [NUM_INPUT];
    logic signed [DATA_WIDTH-1:0] act_q  [2][NUM_HIDDEN];

    int unsigned                  fan_c;
    int unsigned                  nodes_c;
    logic                         is_out_c;
    logic                         last_term_c;
    logic                         last_node_c;
    logic                         rd_bank_c;
    logic                         act_we_c;
    logic signed [DATA_WIDTH-1:0] operand_c;
    logic signed [PROD_W-1:0]     prod_c;
    logic signed [ACC_W-1:0]      term_c;
    logic signed [DATA_WIDTH-1:0] sat_c;
    logic signed [DATA_WIDTH-1:0] result_c;

    // Layer geometry for the node currently being evaluated
    always_comb begin
        is_out_c    = (layer_q == OUT_LAYER);
        fan_c       = (layer_q == '0) ? NUM_INPUT : NUM_HIDDEN;
        nodes_c     = is_out_c ? NUM_OUTPUT : NUM_HIDDEN;
        last_term_c = (32'(k_q) == fan_c);
        last_node_c = (32'(node_q) == nodes_c - 32'd1);
        rd_bank_c   = ~layer_q[0];
    end

    // Operand for term k: input word, previous-layer activation, or 1.0 for the bias
    always_comb begin
        operand_c = ONE;
        if (!last_term_c) begin
            if (layer_q == '0) begin
                for (int unsigned i = 0; i < NUM_INPUT; i++) begin
                    if (32'(k_q) == i) operand_c = in_buf[i];
                end
            end else begin
                for (int unsigned i = 0; i < NUM_HIDDEN; i++) begin
                    if (32'(k_q) == i) operand_c = act_q[rd_bank_c][i];
                end
            end
        end
    end

    always_comb begin
        prod_c = PROD_W'(operand_c) * PROD_W'($signed(i_weight));
        term_c = ACC_W'(prod_c >>> FRAC_BITS);
    end

    // Saturate the accumulator, then ReLU for hidden layers only
    always_comb begin
        if (acc_q > SAT_MAX) begin
            sat_c = DATA_WIDTH'(SAT_MAX);
        end else if (acc_q < SAT_MIN) begin
            sat_c = DATA_WIDTH'(SAT_MIN);
        end else begin
            sat_c = DATA_WIDTH'(acc_q);
        end
        result_c = (!is_out_c && sat_c[DATA_WIDTH-1]) ? '0 : sat_c;
    end

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        node_d   = node_q;
        k_d      = k_q;
        acc_d    = acc_q;
        wreq_d   = 1'b0;
        wlayer_d = wlayer_q;
        waddr_d  = waddr_q;
        dvalid_d = 1'b0;
        dlayer_d = dlayer_q;
        daddr_d  = daddr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        act_we_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = REQ;
                    layer_d = '0;
                    node_d  = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            REQ: begin
                wreq_d   = 1'b1;
                wlayer_d = layer_q;
                waddr_d  = WADDR_WIDTH'(32'(node_q) * (fan_c + 32'd1) + 32'(k_q));
                state_d  = WAIT;
            end
            WAIT: begin
                if (i_weight_valid) begin
                    acc_d = acc_q + term_c;
                    if (last_term_c) begin
                        state_d = FINISH;
                    end else begin
                        k_d     = k_q + K_W'(1);
                        state_d = REQ;
                    end
                end
            end
            FINISH: begin
                dvalid_d = 1'b1;
                dlayer_d = layer_q;
                daddr_d  = node_q;
                data_d   = result_c;
                act_we_c = !is_out_c;
                k_d      = '0;
                acc_d    = '0;
                if (!last_node_c) begin
                    node_d  = node_q + ADDR_WIDTH'(1);
                    state_d = REQ;
                end else if (is_out_c) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    layer_d = layer_q + LAYER_WIDTH'(1);
                    node_d  = '0;
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            layer_q  <= '0;
            node_q   <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            wreq_q   <= 1'b0;
            wlayer_q <= '0;
            waddr_q  <= '0;
            dvalid_q <= 1'b0;
            dlayer_q <= '0;
            daddr_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            node_q   <= node_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            wreq_q   <= wreq_d;
            wlayer_q <= wlayer_d;
            waddr_q  <= waddr_d;
            dvalid_q <= dvalid_d;
            dlayer_q <= dlayer_d;
            daddr_q  <= daddr_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // Storage arrays; hidden layer L writes bank L[0] while reading the other bank
    always_ff @(posedge clk) begin
        if (state_q == IDLE && i_data_valid) begin
            for (int unsigned i = 0; i < NUM_INPUT; i++) begin
                if (32'(i_data_addr) == i) in_buf[i] <= i_data;
            end
        end
        if (act_we_c) begin
            for (int unsigned i = 0; i < NUM_HIDDEN; i++) begin
                if (32'(node_q) == i) act_q[layer_q[0]][i] <= result_c;
            end
        end
    end

    assign o_busy                 = busy_q;
    assign o_weight_valid_request = wreq_q;
    assign o_weight_layer_request = wlayer_q;
    assign o_weight_addr_request  = waddr_q;
    assign o_data_valid           = dvalid_q;
    assign o_data_layer           = dlayer_q;
    assign o_data_addr            = daddr_q;
    assign o_data                 = data_q;
    assign o_done                 = done_q;

endmodule

// File: tb/tb_feed_forward_multi_layer.sv
// Directed bench for feed_forward_multi_layer: 2-2-1 network with a behavioural weight responder.
module tb_feed_forward_multi_layer;

    localparam int unsigned DW  = 16;
    localparam int unsigned LW  = 2;
    localparam int unsigned AW  = 6;
    localparam int unsigned WAW = 11;

    logic           clk;
    logic           rst;
    logic           i_data_valid;
    logic [AW-1:0]  i_data_addr;
    logic [DW-1:0]  i_data;
    logic           i_start;
    logic           o_busy;
    logic           o_weight_valid_request;
    logic [LW-1:0]  o_weight_layer_request;
    logic [WAW-1:0] o_weight_addr_request;
    logic           i_weight_valid;
    logic [DW-1:0]  i_weight;
    logic           o_data_valid;
    logic [LW-1:0]  o_data_layer;
    logic [AW-1:0]  o_data_addr;
    logic [DW-1:0]  o_data;
    logic           o_done;

    feed_forward_multi_layer #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_INPUT(2), .NUM_HIDDEN(2),
        .NUM_HIDDEN_LAYERS(1), .NUM_OUTPUT(1), .LAYER_WIDTH(LW),
        .ADDR_WIDTH(AW), .WADDR_WIDTH(WAW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_data_valid           (i_data_valid),
        .i_data_addr            (i_data_addr),
        .i_data                 (i_data),
        .i_start                (i_start),
        .o_busy                 (o_busy),
        .o_weight_valid_request (o_weight_valid_request),
        .o_weight_layer_request (o_weight_layer_request),
        .o_weight_addr_request  (o_weight_addr_request),
        .i_weight_valid         (i_weight_valid),
        .i_weight               (i_weight),
        .o_data_valid           (o_data_valid),
        .o_data_layer           (o_data_layer),
        .o_data_addr            (o_data_addr),
        .o_data                 (o_data),
        .o_done                 (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Responder configuration and logs
    logic [DW-1:0] wval = 16'h0100;
    int            fixed_lat = 1;
    bit            lat_rand = 1'b0;
    bit            spur_mode = 1'b0;
    int            n_req = 0;
    int            n_overlap = 0;
    logic [31:0]   req_log [64];

    int            n_res = 0;
    int            n_done = 0;
    logic [31:0]   res_log [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Weight responder: one reply per request, optional random latency and spurious pulses
    initial begin
        bit skip;
        int lat;
        skip = 1'b0;
        i_weight_valid = 1'b0;
        i_weight = '0;
        forever begin
            if (!skip) begin
                @(posedge clk);
                #1;
            end
            skip = 1'b0;
            i_weight_valid = spur_mode && !o_busy;
            i_weight = 16'h5555;
            if (o_weight_valid_request) begin
                i_weight_valid = 1'b0;
                if (n_req < 64) req_log[n_req] = {8'(o_weight_layer_request), 8'h00, 16'(o_weight_addr_request)};
                n_req++;
                lat = lat_rand ? int'($urandom_range(10, 1)) : fixed_lat;
                for (int j = 1; j < lat; j++) begin
                    tick();
                    if (o_weight_valid_request) n_overlap++;
                end
                i_weight = wval;
                i_weight_valid = 1'b1;
                tick();
                if (o_weight_valid_request) n_overlap++;
                if (spur_mode) begin
                    i_weight = 16'h1234;
                    tick();
                    skip = 1'b1;
                end
                i_weight_valid = 1'b0;
            end
        end
    end

    // Result monitor
    initial begin
        forever begin
            tick();
            if (o_data_valid) begin
                if (n_res < 8) res_log[n_res] = {8'(o_data_layer), 8'(o_data_addr), o_data};
                n_res++;
            end
            if (o_done) n_done++;
        end
    end

    task automatic write_in(input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_data_valid = 1'b1;
        i_data_addr = a;
        i_data = d;
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic do_run(input string tag, input logic [DW-1:0] h0, input logic [DW-1:0] h1,
                          input logic [DW-1:0] out, input bit chk_addr, input bit poke);
        int cyc;
        logic [31:0] exp_req;
        n_req = 0;
        n_res = 0;
        n_done = 0;
        n_overlap = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check({tag, ".busy_rise"}, 32'(o_busy), 32'd1);
        if (poke) begin
            tick();
            i_data_valid = 1'b1;
            i_data_addr = '0;
            i_data = 16'h7000;
            i_start = 1'b1;
            tick();
            i_data_valid = 1'b0;
            i_start = 1'b0;
        end
        cyc = 0;
        while (!o_done && cyc < 3000) begin
            tick();
            cyc++;
        end
        check({tag, ".done_seen"}, 32'(o_done), 32'd1);
        check({tag, ".busy_at_done"}, 32'(o_busy), 32'd1);
        tick();
        check({tag, ".busy_fall"}, 32'(o_busy), 32'd0);
        repeat (3) tick();
        check({tag, ".done_count"}, 32'(n_done), 32'd1);
        check({tag, ".result_count"}, 32'(n_res), 32'd3);
        check({tag, ".h0"}, res_log[0], {8'd0, 8'd0, h0});
        check({tag, ".h1"}, res_log[1], {8'd0, 8'd1, h1});
        check({tag, ".out"}, res_log[2], {8'd1, 8'd0, out});
        check({tag, ".req_count"}, 32'(n_req), 32'd9);
        check({tag, ".overlap"}, 32'(n_overlap), 32'd0);
        if (chk_addr) begin
            for (int i = 0; i < 9; i++) begin
                exp_req = (i < 6) ? {8'd0, 8'h00, 16'(i)} : {8'd1, 8'h00, 16'(i - 6)};
                check($sformatf("%s.req%0d", tag, i), req_log[i], exp_req);
            end
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        i_data_valid = 1'b0;
        i_data_addr = '0;
        i_data = '0;
        i_start = 1'b0;
        repeat (3) tick();
        check("reset.busy", 32'(o_busy), 32'd0);
        check("reset.wreq", 32'(o_weight_valid_request), 32'd0);
        check("reset.dvalid", 32'(o_data_valid), 32'd0);
        check("reset.done", 32'(o_done), 32'd0);
        check("reset.data", 32'(o_data), 32'd0);
        rst = 1'b0;
        tick();

        // 1.0*1 + 2.0*1 + bias 1 = 4.0 per hidden node; output 4+4+1 = 9.0
        write_in(6'd0, 16'h0100);
        write_in(6'd1, 16'h0200);
        write_in(6'd2, 16'h7777);
        wval = 16'h0100;
        do_run("r025", 16'h0400, 16'h0400, 16'h0900, 1'b1, 1'b0);

        wval = 16'hFF00;
        do_run("r026", 16'h0000, 16'h0000, 16'hFF00, 1'b0, 1'b0);

        write_in(6'd0, 16'h6400);
        write_in(6'd1, 16'h6400);
        wval = 16'h6400;
        do_run("r027", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);

        write_in(6'd0, 16'h0100);
        write_in(6'd1, 16'h0200);
        wval = 16'h0100;
        lat_rand = 1'b1;
        spur_mode = 1'b1;
        repeat (3) tick();
        do_run("r028", 16'h0400, 16'h0400, 16'h0900, 1'b1, 1'b0);
        lat_rand = 1'b0;
        spur_mode = 1'b0;

        // Reset while waiting on the first output-layer weight
        fixed_lat = 3;
        n_req = 0;
        n_res = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0;
        while (!(o_weight_valid_request && o_weight_layer_request == 2'd1) && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("r029.reached_l1", 32'(o_weight_layer_request), 32'd1);
        rst = 1'b1;
        #1;
        check("r029.rst_busy", 32'(o_busy), 32'd0);
        check("r029.rst_wreq", 32'(o_weight_valid_request), 32'd0);
        check("r029.rst_wlayer", 32'(o_weight_layer_request), 32'd0);
        check("r029.rst_data", 32'(o_data), 32'd0);
        check("r029.rst_dlayer", 32'(o_data_layer), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        check("r029.idle_after_late_valid", 32'(o_busy), 32'd0);
        fixed_lat = 1;
        write_in(6'd0, 16'h0100);
        write_in(6'd1, 16'h0200);
        do_run("r029", 16'h0400, 16'h0400, 16'h0900, 1'b1, 1'b0);

        do_run("r030a", 16'h0400, 16'h0400, 16'h0900, 1'b0, 1'b1);
        do_run("r030b", 16'h0400, 16'h0400, 16'h0900, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
